// File: rtl/floor_request_if.sv
// Call/status bundle between the button pulse stages, floor_request_ctrl and the car drivers.
// With ELEV_ESTOP_EN defined, also carries the synchronous emergency stop.
interface floor_request_if #(
  parameter int unsigned FLOORS = 4
) ();
  localparam int unsigned FLOOR_W = $clog2(FLOORS);

  logic [FLOORS-1:0]  call;
  logic [FLOOR_W-1:0] floor;
  logic               moving_up;
  logic               moving_down;
  logic               door_open;
  logic [FLOORS-1:0]  pending;
`ifdef ELEV_ESTOP_EN
  logic               estop;

  modport master (
    output call, estop,
    input  floor, moving_up, moving_down, door_open, pending
  );

  modport slave (
    input  call, estop,
    output floor, moving_up, moving_down, door_open, pending
  );
`else
  modport master (
    output call,
    input  floor, moving_up, moving_down, door_open, pending
  );

  modport slave (
    input  call,
    output floor, moving_up, moving_down, door_open, pending
  );
`endif
endinterface

// File: rtl/floor_request_ctrl.sv
// Single-car SCAN controller: latches floor calls, times travel and door dwell, clears served calls.
// Optional macro ELEV_ESTOP_EN adds the estop freeze input on the interface.
module floor_request_ctrl #(
  parameter int unsigned FLOORS      = 4,
  parameter int unsigned MOVE_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  floor_request_if.slave  bus
);

  localparam int unsigned FLOOR_W = $clog2(FLOORS);
  localparam int unsigned CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] MOVE_LOAD = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DOOR = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic               dir_up_q, dir_up_d;
  logic [FLOORS-1:0]  pending_q, pending_d;
  logic               moving_up_q, moving_down_q, door_open_q;

  logic [FLOORS-1:0]  cur_bit;
  logic [FLOORS-1:0]  clear;
  logic               hit_here;
  logic               call_here;
  logic               req_above;
  logic               req_below;
  logic               hold;

  assign cur_bit   = FLOORS'(1) << floor_q;
  assign hit_here  = ((pending_q | bus.call) & cur_bit) != '0;
  assign call_here = (bus.call & cur_bit) != '0;

`ifdef ELEV_ESTOP_EN
  assign hold = bus.estop;
`else
  assign hold = 1'b0;
`endif

  // Latched requests strictly above / below the car
  always_comb begin
    req_above = 1'b0;
    req_below = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (pending_q[i] && (i > 32'(floor_q))) req_above = 1'b1;
      if (pending_q[i] && (i < 32'(floor_q))) req_below = 1'b1;
    end
  end

  // Next-state, counters, direction and request clear
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    floor_d   = floor_q;
    dir_up_d  = dir_up_q;
    clear     = '0;
    pending_d = pending_q;

    unique case (state_q)
      ST_IDLE: begin
        if (hit_here) begin
          state_d = ST_DOOR;
          cnt_d   = DOOR_LOAD;
        end else if (req_above && (dir_up_q || !req_below)) begin
          state_d  = ST_UP;
          cnt_d    = MOVE_LOAD;
          dir_up_d = 1'b1;
        end else if (req_below) begin
          state_d  = ST_DOWN;
          cnt_d    = MOVE_LOAD;
          dir_up_d = 1'b0;
        end
      end

      ST_UP: begin
        if (cnt_q == '0) begin
          floor_d = floor_q + FLOOR_W'(1);
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DOWN: begin
        if (cnt_q == '0) begin
          floor_d = floor_q - FLOOR_W'(1);
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DOOR: begin
        // A fresh call for this floor keeps the door open for a full dwell
        if (call_here) begin
          cnt_d = DOOR_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (hold) begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      floor_d  = floor_q;
      dir_up_d = dir_up_q;
    end

    // Served floor is cleared on door entry and throughout the dwell; clear beats set
    if ((state_q == ST_DOOR) || (state_d == ST_DOOR)) begin
      clear = cur_bit;
    end
    pending_d = (pending_q | bus.call) & ~clear;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      floor_q       <= '0;
      dir_up_q      <= 1'b1;
      pending_q     <= '0;
      moving_up_q   <= 1'b0;
      moving_down_q <= 1'b0;
      door_open_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      floor_q       <= floor_d;
      dir_up_q      <= dir_up_d;
      pending_q     <= pending_d;
      moving_up_q   <= (state_d == ST_UP);
      moving_down_q <= (state_d == ST_DOWN);
      door_open_q   <= (state_d == ST_DOOR);
    end
  end

  assign bus.floor       = floor_q;
  assign bus.moving_up   = moving_up_q;
  assign bus.moving_down = moving_down_q;
  assign bus.door_open   = door_open_q;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_floor_request_ctrl.sv
// Directed bench for floor_request_ctrl with a per-cycle behavioural model of the car.
module tb_floor_request_ctrl;

  localparam int unsigned FLOORS      = 4;
  localparam int unsigned MOVE_CYCLES = 8;
  localparam int unsigned DOOR_CYCLES = 4;

  typedef enum int {M_IDLE, M_UP, M_DOWN, M_DOOR} mmode_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  floor_request_if #(.FLOORS(FLOORS)) bus ();

  floor_request_ctrl #(
    .FLOORS      (FLOORS),
    .MOVE_CYCLES (MOVE_CYCLES),
    .DOOR_CYCLES (DOOR_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: where the car is, what it is doing, how many cycles of it remain
  int              m_floor  = 0;
  bit              m_dir_up = 1'b1;
  mmode_t          m_mode   = M_IDLE;
  int              m_left   = 0;
  bit [FLOORS-1:0] m_pend   = '0;
  bit [FLOORS-1:0] m_call;
  bit              m_above, m_below, m_frozen;
  mmode_t          m_prev;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_floor  = 0;
      m_dir_up = 1'b1;
      m_mode   = M_IDLE;
      m_left   = 0;
      m_pend   = '0;
    end else begin
      m_call   = bus.call;
`ifdef ELEV_ESTOP_EN
      m_frozen = bus.estop;
`else
      m_frozen = 1'b0;
`endif
      m_prev   = m_mode;
      if (!m_frozen) begin
        case (m_mode)
          M_IDLE: begin
            m_above = 1'b0;
            m_below = 1'b0;
            for (int f = 0; f < int'(FLOORS); f++) begin
              if (m_pend[f] && f > m_floor) m_above = 1'b1;
              if (m_pend[f] && f < m_floor) m_below = 1'b1;
            end
            if (m_pend[m_floor] || m_call[m_floor]) begin
              m_mode = M_DOOR; m_left = DOOR_CYCLES;
            end else if (m_above && (m_dir_up || !m_below)) begin
              m_mode = M_UP; m_left = MOVE_CYCLES; m_dir_up = 1'b1;
            end else if (m_below) begin
              m_mode = M_DOWN; m_left = MOVE_CYCLES; m_dir_up = 1'b0;
            end
          end
          M_UP, M_DOWN: begin
            m_left--;
            if (m_left == 0) begin
              m_floor = (m_mode == M_UP) ? m_floor + 1 : m_floor - 1;
              m_mode  = M_IDLE;
            end
          end
          default: begin
            if (m_call[m_floor]) m_left = DOOR_CYCLES;
            else begin
              m_left--;
              if (m_left == 0) m_mode = M_IDLE;
            end
          end
        endcase
      end
      m_pend = m_pend | m_call;
      if (m_prev == M_DOOR || m_mode == M_DOOR) m_pend[m_floor] = 1'b0;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("floor",       32'(bus.floor),       32'(m_floor));
      check("moving_up",   32'(bus.moving_up),   32'(m_mode == M_UP));
      check("moving_down", 32'(bus.moving_down), 32'(m_mode == M_DOWN));
      check("door_open",   32'(bus.door_open),   32'(m_mode == M_DOOR));
      check("pending",     32'(bus.pending),     32'(m_pend));
    end
  end

  int up_cnt, dn_cnt, door_cnt, door_len, up_len;
  bit last_door;
  int door_floors[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [FLOORS-1:0] v);
    bus.call = v;
    tick(1);
    bus.call = '0;
  endtask

  task automatic clear_stats();
    up_cnt = 0; dn_cnt = 0; door_cnt = 0; last_door = 1'b0;
    door_floors.delete();
  endtask

  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (bus.moving_up)   up_cnt++;
      if (bus.moving_down) dn_cnt++;
      if (bus.door_open) begin
        door_cnt++;
        if (!last_door) door_floors.push_back(int'(bus.floor));
      end
      last_door = bus.door_open;
    end
  endtask

  initial begin
    bus.call = '0;
`ifdef ELEV_ESTOP_EN
    bus.estop = 1'b0;
`endif
    // Reset then idle
    tick(3);
    reset  = 1'b1;
    chk_en = 1'b1;
    check("rst_floor",   32'(bus.floor), 32'd0);
    check("rst_pending", 32'(bus.pending), 32'd0);
    tick(20);
    check("idle_outs", {29'd0, bus.moving_up, bus.moving_down, bus.door_open}, 32'd0);
    check("idle_floor", 32'(bus.floor), 32'd0);

    // Single trip to the top floor, including the two-edge start latency
    pulse(4'b1000);
    check("trip_pending", 32'(bus.pending), 32'h8);
    check("trip_lat_up0", 32'(bus.moving_up), 32'd0);
    clear_stats();
    observe(40);
    check("trip_up_cycles",   32'(up_cnt),   32'd24);
    check("trip_door_cycles", 32'(door_cnt), 32'd4);
    check("trip_door_floor",  32'(door_floors.size() > 0 ? door_floors[0] : -1), 32'd3);
    check("trip_floor",       32'(bus.floor), 32'd3);
    check("trip_pending_end", 32'(bus.pending), 32'd0);

    // Go to floor 0, then up to floor 1 so the car sits at 1 heading up
    clear_stats();
    pulse(4'b0001);
    observe(40);
    check("down3_cycles", 32'(dn_cnt), 32'd24);
    check("down3_floor",  32'(bus.floor), 32'd0);
    pulse(4'b0010);
    observe(20);
    check("at1_floor", 32'(bus.floor), 32'd1);

    // SCAN: calls above and below, current direction up wins
    clear_stats();
    pulse(4'b1001);
    check("scan_pending", 32'(bus.pending), 32'h9);
    observe(70);
    check("scan_nstops", 32'(door_floors.size()), 32'd2);
    check("scan_first",  32'(door_floors.size() > 0 ? door_floors[0] : -1), 32'd3);
    check("scan_second", 32'(door_floors.size() > 1 ? door_floors[1] : -1), 32'd0);
    check("scan_up",     32'(up_cnt), 32'd16);
    check("scan_down",   32'(dn_cnt), 32'd24);
    check("scan_pending_end", 32'(bus.pending), 32'd0);

    // Door extension at floor 2: re-call on dwell cycle 3
    pulse(4'b0100);
    door_len = 0;
    for (int i = 0; i < 40 && !bus.door_open; i++) tick(1);
    if (!bus.door_open) check("ext_door_timeout", 32'd0, 32'd1);
    else begin
      door_len = 1;
      for (int i = 0; i < 20; i++) begin
        if (i == 2) bus.call = 4'b0100;
        tick(1);
        bus.call = '0;
        if (!bus.door_open) break;
        door_len++;
      end
    end
    check("ext_door_len", 32'(door_len), 32'd7);
    check("ext_floor",    32'(bus.floor), 32'd2);
    check("ext_pending",  32'(bus.pending), 32'd0);
    tick(3);

    // Asynchronous reset in the middle of an upward move
    pulse(4'b1000);
    tick(5);
    check("mid_up", 32'(bus.moving_up), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_floor",   32'(bus.floor), 32'd0);
    check("arst_outs",    {29'd0, bus.moving_up, bus.moving_down, bus.door_open}, 32'd0);
    check("arst_pending", 32'(bus.pending), 32'd0);
    tick(2);
    reset = 1'b1;
    clear_stats();
    observe(10);
    check("post_rst_idle", 32'(up_cnt + dn_cnt + door_cnt), 32'd0);

`ifdef ELEV_ESTOP_EN
    // Emergency stop for 10 cycles during an upward move
    pulse(4'b0010);
    up_len = 0;
    for (int i = 0; i < 10 && !bus.moving_up; i++) tick(1);
    if (!bus.moving_up) check("estop_up_timeout", 32'd0, 32'd1);
    else begin
      up_len = 1;
      for (int i = 0; i < 40; i++) begin
        if (i == 2)  bus.estop = 1'b1;
        if (i == 12) bus.estop = 1'b0;
        tick(1);
        if (i == 7) begin
          check("estop_floor",  32'(bus.floor), 32'd0);
          check("estop_moving", 32'(bus.moving_up), 32'd1);
        end
        if (!bus.moving_up) break;
        up_len++;
      end
    end
    check("estop_travel", 32'(up_len), 32'd18);
    check("estop_arrive", 32'(bus.floor), 32'd1);
    tick(10);
`endif

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/floor_request_ctrl.md
# floor_request_ctrl

- Downstream consumer of the single-cycle call pulses produced by the per-floor button pulse stages.
- Latches one pending request per floor and runs a single car with a SCAN (keep-direction) policy.
- Times inter-floor travel and door dwell, and clears each request when the car serves that floor.
- Feeds the car motor/door drivers and the floor indicator.

## Interface

Parameters:
- FLOORS, 4: number of floors, minimum 2. Floors are indexed 0 to FLOORS-1; floor 0 is the bottom.
- MOVE_CYCLES, 8: clock cycles to travel one floor. Minimum 1.
- DOOR_CYCLES, 4: clock cycles the door stays open per service. Minimum 1.

Ports:
- clk  in  1: system clock. All logic is clocked on the rising edge.
- reset  in  1: asynchronous, active-low reset. Asserts immediately; deassertion is synchronised externally.
- call  in  FLOORS: one-cycle request pulses, one bit per floor. Multiple bits may be high together.
- floor  out  $clog2(FLOORS): current car floor.
- moving_up  out  1: high while the car is travelling upward.
- moving_down  out  1: high while the car is travelling downward.
- door_open  out  1: high while the door dwells open.
- pending  out  FLOORS: latched, not-yet-served requests.

## Operation

States:
- IDLE
- UP: travelling up one floor.
- DOWN: travelling down one floor.
- DOOR: door dwell.

Direction flag `dir` (up or down) is internal and only updates on a direction decision.

Request latching:
- Every cycle: `pending <= (pending | call) & ~clear`.
- `clear` is the current-floor bit on the cycle DOOR is entered, and on every DOOR cycle.

IDLE decision, made on every cycle spent in IDLE:
- `pending[floor] | call[floor]` → go to DOOR.
- Otherwise, requests above and requests below are both considered:
  - Requests above and (`dir` = up or none below) → go to UP, set `dir` = up.
  - Otherwise, requests below → go to DOWN, set `dir` = down.
  - Neither → stay in IDLE.

UP/DOWN:
- Travel counter loads MOVE_CYCLES-1 on entry and decrements each cycle.
- At 0, `floor` increments (UP) or decrements (DOWN) and the state becomes IDLE, which re-decides on the next cycle.
- `floor` never wraps. UP is unreachable at FLOORS-1 and DOWN is unreachable at 0, because no requests exist beyond those ends.

DOOR:
- Dwell counter loads DOOR_CYCLES-1 on entry; the state returns to IDLE when it reaches 0.
- A `call` for the current floor during DOOR reloads the counter, extending the dwell, and is not latched.
- Calls for other floors during DOOR latch normally.

Outputs are registered decodes of the state:
- `moving_up` = (state == UP)
- `moving_down` = (state == DOWN)
- `door_open` = (state == DOOR)

Reset mid-operation:
- All state is discarded immediately.
- The car reports floor 0, even if physically elsewhere. The system-level homing sequence is outside this block.

## Timing

Reset values:
- `floor` = 0, state IDLE, `dir` = up.
- `pending` = 0, `moving_up` = 0, `moving_down` = 0, `door_open` = 0.

Latencies:
- `call` pulse at edge t → `pending` bit visible after edge t+1.
- From IDLE, a call to another floor at edge t → moving output high after edge t+2, once the latch and the decision have each taken one edge.
- Call for the current floor while in IDLE at edge t → `door_open` after edge t+1; `pending` for that floor stays 0.
- One-floor trip: the moving output is high for exactly MOVE_CYCLES cycles, then one IDLE cycle.
- Each further floor costs MOVE_CYCLES+1 cycles.
- Dwell: `door_open` is high for exactly DOOR_CYCLES cycles unless extended.
- Simultaneous events:
  - Set and clear of the same `pending` bit in one cycle → clear wins.
  - Requests above and below in IDLE → `dir` decides.

## Configuration

- Macro `ELEV_ESTOP_EN`.
- Defined:
  - Adds input `estop` (1 bit, active-high, synchronous).
  - While `estop` = 1, the travel and dwell counters hold, the state does not advance, and `pending` still latches.
  - The state is frozen and outputs hold their values.
  - Releasing `estop` resumes from the frozen counter value.
- Undefined: the port is absent and the behaviour is exactly as above.

## Test plan

Defaults throughout: FLOORS=4, MOVE_CYCLES=8, DOOR_CYCLES=4.

- Reset then idle: after reset, with no calls for 20 cycles → `floor`=0, all outputs 0, `pending`=0.
- Single trip: `call`=4'b1000 for one cycle.
  - `pending`=4'b1000.
  - `moving_up` high for 3×8 cycles, separated by single IDLE cycles.
  - `floor` steps 1, 2, 3.
  - `door_open` high for 4 cycles; `pending` cleared when the door opens.
- SCAN order: at floor 1 with `dir`=up, issue `call`=4'b1001.
  - Car serves floor 3 first, then reverses to floor 0.
  - `pending` ends at 0.
- Door extension: during DOOR at floor 2, pulse `call`=4'b0100 on dwell cycle 3 → `door_open` lasts 3+4=7 cycles total; `pending[2]` stays 0.
- Async reset mid-travel: assert `reset`=0 midway through UP → outputs go to reset values immediately, without waiting for a clock edge.
- With `ELEV_ESTOP_EN`: assert `estop` for 10 cycles during UP.
  - `moving_up` stays high and `floor` is unchanged.
  - Total travel time grows by exactly 10 cycles.
